vc_bus_responder: RTL and testbench

Target-side endpoint of the VC CPU's 8-bit multiplexed external bus. It decodes the latch_hi / latch_lo / write / ind strobes driven by the CPU bus bridge, holds a small byte-addressed register file plus a doorbell register, and returns read bytes on the bridge's 8-bit input. It also raises an interrupt line for the CPU. It sits off-chip of the CPU, or in a test harness, wired pin-for-pin to the bridge.

---
 rtl/vc_bus_pkg.sv | 19 +
 rtl/vc_bus_regfile.sv | 52 +++++
 rtl/vc_bus_responder.sv | 163 ++++++++++++++++
 tb/tb_vc_bus_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vc_bus_pkg.sv
// Shared definitions for the VC external-bus responder: bus width, the
// doorbell offset and the bus-cycle state encoding.
package vc_bus_pkg;

  localparam int BUS_W = 8;

  // Low address byte of the doorbell register inside the responder window.
  localparam logic [BUS_W-1:0] DOORBELL_OFF = 8'hFE;

  // Bus-cycle phases: waiting for the high byte, expecting the low byte,
  // first (even) data cycle, second (odd) data cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ALO  = 2'd1,
    D0   = 2'd2,
    D1   = 2'd3
  } bus_state_e;

endpackage

// File: rtl/vc_bus_regfile.sv
// Byte-addressed flop register file: one write port, and two combinational
// read ports returning the even and odd byte of the addressed byte pair.
module vc_bus_regfile
  import vc_bus_pkg::*;
#(
  parameter int MEM_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [MEM_BITS-1:0] waddr,
  input  logic [BUS_W-1:0]    wdata,
  input  logic [MEM_BITS-1:0] raddr,
  output logic [BUS_W-1:0]    rd_even,
  output logic [BUS_W-1:0]    rd_odd
);

  localparam int DEPTH = 2 ** MEM_BITS;

  logic [BUS_W-1:0]    mem_q [DEPTH];
  logic [MEM_BITS-1:0] even_addr;
  logic [MEM_BITS-1:0] odd_addr;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_byte
      logic [BUS_W-1:0] byte_q;

      // One byte of storage; cleared by reset, loaded when addressed.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          byte_q <= '0;
        end else if (we && (waddr == MEM_BITS'(gi))) begin
          byte_q <= wdata;
        end
      end

      assign mem_q[gi] = byte_q;
    end
  endgenerate

  // Both lanes of the pair containing raddr, regardless of raddr bit 0.
  always_comb begin
    even_addr    = raddr;
    even_addr[0] = 1'b0;
    odd_addr     = raddr;
    odd_addr[0]  = 1'b1;
  end

  assign rd_even = mem_q[even_addr];
  assign rd_odd  = mem_q[odd_addr];

endmodule

// File: rtl/vc_bus_responder.sv
// Target-side endpoint of the VC CPU multiplexed 8-bit bus: tracks the
// address/data phases, decodes its window, holds the register file and
// the doorbell, and drives read bytes back to the bridge.
module vc_bus_responder
  import vc_bus_pkg::*;
#(
  parameter logic [7:0] BASE_HI  = 8'h80,
  parameter int         MEM_BITS = 6
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic [BUS_W-1:0] bus_in,
  input  logic             latch_hi,
  input  logic             latch_lo,
  input  logic             write,
  input  logic             ind,
  output logic [BUS_W-1:0] rd_data,
  output logic             rd_oe,
  output logic             irq
);

  localparam logic [8:0] MEM_SIZE = 9'(2 ** MEM_BITS);

  bus_state_e       state_q;
  logic [BUS_W-1:0] hi_q;
  logic [BUS_W-1:0] lo_q;
  logic [BUS_W-1:0] doorbell_q;
  logic             irq_q;

  logic             rd_en;
  logic [BUS_W-1:0] rd_lo;
  logic             wr_en;
  logic [BUS_W-1:0] wr_lo;
  logic             db_we;
  logic             db_clr;
  logic             rf_we;
  logic [BUS_W-1:0] rf_even;
  logic [BUS_W-1:0] rf_odd;

  // Offset 0xFF is deliberately outside the window: reads of it give 0
  // and writes to it vanish.
  function automatic logic is_sel(input logic [7:0] h, input logic [7:0] l);
    return (h == BASE_HI) && (({1'b0, l} < MEM_SIZE) || (l == DOORBELL_OFF));
  endfunction

  // Per-phase decode of which byte is read and which byte is written.
  always_comb begin
    rd_en  = 1'b0;
    rd_lo  = lo_q | 8'h01;
    wr_en  = 1'b0;
    wr_lo  = lo_q;
    db_clr = 1'b0;
    case (state_q)
      ALO: begin
        rd_lo = bus_in;
        rd_en = latch_lo && is_sel(hi_q, bus_in);
      end
      D0: begin
        if (write && !ind) begin
          wr_lo = lo_q;
          wr_en = is_sel(hi_q, lo_q);
        end else if (!write && ind) begin
          // The odd byte is served whenever the even base address hit.
          rd_en  = is_sel(hi_q, lo_q);
          db_clr = (hi_q == BASE_HI) && (lo_q == DOORBELL_OFF);
        end
      end
      D1: begin
        if (write && ind) begin
          wr_lo = lo_q | 8'h01;
          wr_en = is_sel(hi_q, lo_q | 8'h01);
        end
      end
      default: ;
    endcase
  end

  assign db_we = wr_en && (wr_lo == DOORBELL_OFF);
  assign rf_we = wr_en && (wr_lo != DOORBELL_OFF);

  vc_bus_regfile #(
    .MEM_BITS (MEM_BITS)
  ) u_regfile (
    .clk     (clk),
    .rst     (reset_in),
    .we      (rf_we),
    .waddr   (wr_lo[MEM_BITS-1:0]),
    .wdata   (bus_in),
    .raddr   (rd_lo[MEM_BITS-1:0]),
    .rd_even (rf_even),
    .rd_odd  (rf_odd)
  );

  // Read-byte mux: doorbell, register-file lane, or zero (covers 0xFF).
  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      if (rd_lo == DOORBELL_OFF) begin
        rd_data = doorbell_q;
      end else if ({1'b0, rd_lo} < MEM_SIZE) begin
        rd_data = rd_lo[0] ? rf_odd : rf_even;
      end
    end
  end

  assign rd_oe = rd_en;
  assign irq   = irq_q;

  // Bus-phase FSM with address capture, doorbell storage and irq flag.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      doorbell_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (latch_hi) begin
            hi_q    <= bus_in;
            state_q <= ALO;
          end
        end
        ALO: begin
          if (latch_lo) begin
            lo_q    <= bus_in;
            state_q <= D0;
          end else begin
            state_q <= IDLE;
          end
        end
        D0: begin
          if (write && !ind) begin
            state_q <= D1;
          end else begin
            state_q <= IDLE;
          end
        end
        D1: begin
          if (write && ind) begin
            state_q <= IDLE;
          end else if (latch_hi) begin
            // Back-to-back: the next access's high byte arrives here.
            hi_q    <= bus_in;
            state_q <= ALO;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (db_we) begin
        doorbell_q <= bus_in;
        irq_q      <= 1'b1;
      end else if (db_clr) begin
        irq_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vc_bus_responder.sv
// Scoreboard bench for vc_bus_responder: bus transactions update a small
// reference model, read cycles push expected bytes that are popped and
// compared when the responder drives them.
module tb_vc_bus_responder;

  logic       clk = 1'b0;
  logic       reset_in = 1'b1;
  logic [7:0] bus_in = 8'h00;
  logic       latch_hi = 1'b0;
  logic       latch_lo = 1'b0;
  logic       write = 1'b0;
  logic       ind = 1'b0;
  logic [7:0] rd_data;
  logic       rd_oe;
  logic       irq;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q [$];
  logic [7:0] m_mem [64];
  logic [7:0] m_db;
  logic       m_irq;

  vc_bus_responder #(
    .BASE_HI  (8'h80),
    .MEM_BITS (6)
  ) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .bus_in   (bus_in),
    .latch_hi (latch_hi),
    .latch_lo (latch_lo),
    .write    (write),
    .ind      (ind),
    .rd_data  (rd_data),
    .rd_oe    (rd_oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic m_sel(input logic [7:0] h, input logic [7:0] l);
    return (h == 8'h80) && ((l < 8'h40) || (l == 8'hFE));
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
    m_db  = 8'h00;
    m_irq = 1'b0;
  endtask

  task automatic m_write(input logic [7:0] h, input logic [7:0] l, input logic [7:0] d);
    if (m_sel(h, l)) begin
      if (l == 8'hFE) begin
        m_db  = d;
        m_irq = 1'b1;
      end else begin
        m_mem[l[5:0]] = d;
      end
    end
  endtask

  // One bus cycle: drive, sample mid-cycle (popping an expectation when
  // asked), then move just past the rising edge that ends the cycle.
  task automatic step(input logic [7:0] b, input logic lh, input logic ll,
                      input logic wr, input logic id, input logic chk, input string tag);
    logic [8:0] e;
    bus_in = b; latch_hi = lh; latch_lo = ll; write = wr; ind = id;
    @(negedge clk);
    if (chk) begin
      if (exp_q.size() == 0) begin
        check({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_oe"}, {31'd0, rd_oe}, {31'd0, e[8]});
        check({tag, "_data"}, {24'd0, rd_data}, {24'd0, e[7:0]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
  endtask

  task automatic wr_byte(input logic [7:0] h, input logic [7:0] l, input logic [7:0] d);
    step(h, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "wb_hi");
    step(l, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "wb_lo");
    step(d, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "wb_d");
    m_write(h, l, d);
    $display("write byte %02h%02h = %02h", h, l, d);
  endtask

  task automatic wr_word(input logic [7:0] h, input logic [7:0] l, input logic [7:0] d0, input logic [7:0] d1);
    step(h, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "ww_hi");
    step(l, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "ww_lo");
    step(d0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "ww_d0");
    step(d1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "ww_d1");
    m_write(h, l, d0);
    m_write(h, l | 8'h01, d1);
    $display("write word %02h%02h = %02h%02h", h, l, d1, d0);
  endtask

  task automatic rd_word(input logic [7:0] h, input logic [7:0] l);
    logic [7:0] lo_b;
    logic [7:0] hi_b;
    lo_b = (l == 8'hFE) ? m_db : m_mem[l[5:0]];
    hi_b = (l == 8'hFE) ? 8'h00 : m_mem[l[5:0] | 6'h01];
    step(h, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rw_hi");
    exp_q.push_back(m_sel(h, l) ? {1'b1, lo_b} : 9'h000);
    step(l, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "rd_lo");
    exp_q.push_back(m_sel(h, l) ? {1'b1, hi_b} : 9'h000);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "rd_hi");
    if (h == 8'h80 && l == 8'hFE) m_irq = 1'b0;
    $display("read word %02h%02h expect %02h%02h", h, l, hi_b, lo_b);
  endtask

  initial begin
    m_clear();

    // Reset state with reset held.
    #3;
    check("reset_oe", {31'd0, rd_oe}, 32'd0);
    check("reset_data", {24'd0, rd_data}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    reset_in = 1'b0;
    idle(2);

    // Word write then word read.
    wr_word(8'h80, 8'h10, 8'hEF, 8'hBE);
    idle(1);
    rd_word(8'h80, 8'h10);

    // High-lane byte write, then read of the containing pair.
    wr_byte(8'h80, 8'h21, 8'h5A);
    idle(1);
    rd_word(8'h80, 8'h20);

    // Unselected/unmapped writes leave state alone.
    wr_byte(8'h81, 8'h10, 8'h11);
    idle(1);
    wr_word(8'h80, 8'h40, 8'h22, 8'h33);
    rd_word(8'h81, 8'h10);
    rd_word(8'h80, 8'h40);
    rd_word(8'h80, 8'h10);
    check("unmapped_irq", {31'd0, irq}, {31'd0, m_irq});

    // Protocol error in ALO: no latch_lo, so nothing happens.
    step(8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "pe_hi");
    step(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "pe_nolo");
    step(8'h99, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "pe_d");
    rd_word(8'h80, 8'h12);

    // Doorbell ring and clear.
    wr_byte(8'h80, 8'hFE, 8'h33);
    check("db_irq_set", {31'd0, irq}, 32'd1);
    idle(1);
    check("db_irq_hold", {31'd0, irq}, 32'd1);
    rd_word(8'h80, 8'hFE);
    check("db_irq_clr", {31'd0, irq}, 32'd0);

    // Back-to-back: latch_hi in the D1 cycle right after a byte write.
    wr_byte(8'h80, 8'h30, 8'hC3);
    rd_word(8'h80, 8'h30);
    wr_byte(8'h80, 8'h05, 8'h7E);
    wr_byte(8'h80, 8'h06, 8'h81);
    rd_word(8'h80, 8'h04);
    rd_word(8'h80, 8'h06);

    // Random word traffic inside the window.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 31) * 2);
      wr_word(8'h80, a, 8'($urandom), 8'($urandom));
      if (i[0]) idle(1);
      rd_word(8'h80, a);
    end

    // Reset between the two data cycles of a word write, with irq raised.
    wr_byte(8'h80, 8'hFE, 8'h44);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    step(8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rs_hi");
    step(8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "rs_lo");
    step(8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "rs_d0");
    bus_in = 8'hBB; write = 1'b1; ind = 1'b1;
    #2;
    reset_in = 1'b1;
    #1;
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_oe", {31'd0, rd_oe}, 32'd0);
    check("rst_data", {24'd0, rd_data}, 32'd0);
    @(posedge clk); #1;
    reset_in = 1'b0;
    m_clear();
    idle(1);
    rd_word(8'h80, 8'h10);
    rd_word(8'h80, 8'h20);
    rd_word(8'h80, 8'hFE);
    rd_word(8'h80, 8'h30);
    check("post_rst_irq", {31'd0, irq}, 32'd0);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
